// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap controller for the RV32I core.
// Combinational CSR read port, 64-bit counters, registered PC redirect on trap/interrupt/mret.
module csr_unit #(
   parameter logic [31:0] HART_ID   = 32'd0,
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] csr_rd_addr,
   output logic [31:0] csr_rd_data,
   output logic        csr_illegal,
   input  logic        csr_wr,
   input  logic [11:0] csr_wr_addr,
   input  logic [31:0] csr_wr_data,
   input  logic [31:0] pc,
   input  logic        trap,
   input  logic        mret,
   input  logic        retire,
   input  logic        EIP,
   output logic        IRQ_complete,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MISA     = 12'h301;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MINSTRET = 12'hB02;
   localparam logic [11:0] A_MCYCLEH  = 12'hB80;
   localparam logic [11:0] A_MINSTRH  = 12'hB82;
   localparam logic [11:0] A_CYCLE    = 12'hC00;
   localparam logic [11:0] A_INSTRET  = 12'hC02;
   localparam logic [11:0] A_CYCLEH   = 12'hC80;
   localparam logic [11:0] A_INSTRH   = 12'hC82;
   localparam logic [11:0] A_MHARTID  = 12'hF14;

   logic        mie_q, mie_d;
   logic        mpie_q, mpie_d;
   logic        meie_q, meie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [63:0] mcycle_q, mcycle_d;
   logic [63:0] minstret_q, minstret_d;
   logic        in_irq_q, in_irq_d;
   logic        redirect_valid_q, redirect_valid_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        irq_complete_q, irq_complete_d;

   logic        rd_impl_s;
   logic        wr_en_s;
   logic        take_trap_s;
   logic        take_irq_s;
   logic        take_mret_s;

   // Combinational read mux over the implemented CSR map.
   always_comb begin
      csr_rd_data = 32'd0;
      rd_impl_s   = 1'b1;
      case (csr_rd_addr)
         A_MSTATUS:            csr_rd_data = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
         A_MISA:               csr_rd_data = 32'h4000_0100;
         A_MIE:                csr_rd_data = {20'd0, meie_q, 11'd0};
         A_MTVEC:              csr_rd_data = mtvec_q;
         A_MSCRATCH:           csr_rd_data = mscratch_q;
         A_MEPC:               csr_rd_data = mepc_q;
         A_MCAUSE:             csr_rd_data = mcause_q;
         A_MIP:                csr_rd_data = {20'd0, EIP, 11'd0};
         A_MCYCLE,   A_CYCLE:   csr_rd_data = mcycle_q[31:0];
         A_MCYCLEH,  A_CYCLEH:  csr_rd_data = mcycle_q[63:32];
         A_MINSTRET, A_INSTRET: csr_rd_data = minstret_q[31:0];
         A_MINSTRH,  A_INSTRH:  csr_rd_data = minstret_q[63:32];
         A_MHARTID:            csr_rd_data = HART_ID;
         default: begin
            csr_rd_data = 32'd0;
            rd_impl_s   = 1'b0;
         end
      endcase
   end

   assign wr_en_s     = csr_wr & (csr_wr_addr[11:10] != 2'b11);
   assign csr_illegal = ~rd_impl_s | (csr_wr & (csr_wr_addr[11:10] == 2'b11));

   // trap beats interrupt beats mret
   assign take_trap_s = trap;
   assign take_irq_s  = ~trap & EIP & meie_q & mie_q;
   assign take_mret_s = ~trap & ~take_irq_s & mret;

   // Next-state: CSR writes first, then event updates override them.
   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      meie_d     = meie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = retire ? (minstret_q + 64'd1) : minstret_q;
      in_irq_d   = in_irq_q;

      if (wr_en_s) begin
         case (csr_wr_addr)
            A_MSTATUS: begin
               mie_d  = csr_wr_data[3];
               mpie_d = csr_wr_data[7];
            end
            A_MIE:      meie_d     = csr_wr_data[11];
            A_MTVEC:    mtvec_d    = {csr_wr_data[31:2], 2'b00};
            A_MSCRATCH: mscratch_d = csr_wr_data;
            A_MEPC:     mepc_d     = {csr_wr_data[31:2], 2'b00};
            A_MCAUSE:   mcause_d   = csr_wr_data;
            A_MCYCLE:   mcycle_d   = {mcycle_q[63:32], csr_wr_data};
            A_MCYCLEH:  mcycle_d   = {csr_wr_data, mcycle_q[31:0]};
            A_MINSTRET: minstret_d = {minstret_q[63:32], csr_wr_data};
            A_MINSTRH:  minstret_d = {csr_wr_data, minstret_q[31:0]};
            default:    mie_d      = mie_q;
         endcase
      end else begin
         mie_d = mie_q;
      end

      if (take_trap_s || take_irq_s) begin
         mepc_d   = pc;
         mcause_d = take_trap_s ? 32'd3 : 32'h8000_000B;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
         in_irq_d = take_irq_s ? 1'b1 : in_irq_q;
      end else if (take_mret_s) begin
         mie_d    = mpie_q;
         mpie_d   = 1'b1;
         in_irq_d = 1'b0;
      end else begin
         in_irq_d = in_irq_q;
      end

      redirect_valid_d = take_trap_s | take_irq_s | take_mret_s;
      irq_complete_d   = take_mret_s & in_irq_q;
      if (take_mret_s) begin
         redirect_pc_d = mepc_q;
      end else if (take_trap_s || take_irq_s) begin
         redirect_pc_d = mtvec_q;
      end else begin
         redirect_pc_d = redirect_pc_q;
      end
   end

   // State and registered-output flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mie_q            <= 1'b0;
         mpie_q           <= 1'b0;
         meie_q           <= 1'b0;
         mtvec_q          <= RESET_VEC;
         mscratch_q       <= 32'd0;
         mepc_q           <= 32'd0;
         mcause_q         <= 32'd0;
         mcycle_q         <= 64'd0;
         minstret_q       <= 64'd0;
         in_irq_q         <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= 32'd0;
         irq_complete_q   <= 1'b0;
      end else begin
         mie_q            <= mie_d;
         mpie_q           <= mpie_d;
         meie_q           <= meie_d;
         mtvec_q          <= mtvec_d;
         mscratch_q       <= mscratch_d;
         mepc_q           <= mepc_d;
         mcause_q         <= mcause_d;
         mcycle_q         <= mcycle_d;
         minstret_q       <= minstret_d;
         in_irq_q         <= in_irq_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         irq_complete_q   <= irq_complete_d;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign IRQ_complete   = irq_complete_q;

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: stimulus queues expected reads/redirects,
// a negedge monitor pops and compares them against the DUT.
module tb_csr_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] csr_rd_addr = 12'h000;
   logic [31:0] csr_rd_data;
   logic        csr_illegal;
   logic        csr_wr = 1'b0;
   logic [11:0] csr_wr_addr = 12'h000;
   logic [31:0] csr_wr_data = 32'd0;
   logic [31:0] pc = 32'd0;
   logic        trap = 1'b0;
   logic        mret = 1'b0;
   logic        retire = 1'b0;
   logic        EIP = 1'b0;
   logic        IRQ_complete;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   logic        rd_chk = 1'b0;
   int          checks = 0;
   int          passes = 0;

   logic [31:0] rd_exp_q[$];
   logic        rd_ill_q[$];
   string       rd_nm_q[$];
   logic [31:0] rr_pc_q[$];
   logic        rr_irq_q[$];
   string       rr_nm_q[$];

   always #5 clk = ~clk;

   csr_unit #(.HART_ID(32'd5), .RESET_VEC(32'h0000_0200)) dut (
      .clk(clk), .reset(reset),
      .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data), .csr_illegal(csr_illegal),
      .csr_wr(csr_wr), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
      .pc(pc), .trap(trap), .mret(mret), .retire(retire), .EIP(EIP),
      .IRQ_complete(IRQ_complete), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Monitor: compare combinational reads and registered redirect pulses.
   always @(negedge clk) begin
      if (rd_chk) begin
         if (rd_exp_q.size() == 0) begin
            checks++;
            $display("FAIL rd_unexpected: read strobe with empty scoreboard at addr %h", csr_rd_addr);
         end else begin
            string       nm;
            logic [31:0] e;
            logic        il;
            nm = rd_nm_q.pop_front();
            e  = rd_exp_q.pop_front();
            il = rd_ill_q.pop_front();
            chk(nm, csr_rd_data, e);
            chk({nm, "_illegal"}, {31'd0, csr_illegal}, {31'd0, il});
         end
      end
      if (redirect_valid) begin
         if (rr_pc_q.size() == 0) begin
            checks++;
            $display("FAIL redirect_unexpected: got pc %h irq_complete %b expected no redirect", redirect_pc, IRQ_complete);
         end else begin
            string       nm;
            logic [31:0] e;
            logic        ic;
            nm = rr_nm_q.pop_front();
            e  = rr_pc_q.pop_front();
            ic = rr_irq_q.pop_front();
            chk({nm, "_pc"}, redirect_pc, e);
            chk({nm, "_irq_complete"}, {31'd0, IRQ_complete}, {31'd0, ic});
         end
      end else if (IRQ_complete) begin
         checks++;
         $display("FAIL irq_complete_stray: got 1 expected 0 without redirect");
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
      csr_wr = 1'b0;
      trap   = 1'b0;
      mret   = 1'b0;
      rd_chk = 1'b0;
   endtask

   task automatic push_rd(input string nm, input logic [11:0] a, input logic [31:0] e, input logic il);
      csr_rd_addr = a;
      rd_chk      = 1'b1;
      rd_nm_q.push_back(nm);
      rd_exp_q.push_back(e);
      rd_ill_q.push_back(il);
   endtask

   task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] e, input logic il);
      next();
      push_rd(nm, a, e, il);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      next();
      csr_wr      = 1'b1;
      csr_wr_addr = a;
      csr_wr_data = d;
   endtask

   task automatic wrd(input logic [11:0] wa, input logic [31:0] d, input string nm,
                      input logic [11:0] ra, input logic [31:0] e, input logic il);
      wr(wa, d);
      push_rd(nm, ra, e, il);
   endtask

   task automatic exp_redirect(input string nm, input logic [31:0] p, input logic ic);
      rr_nm_q.push_back(nm);
      rr_pc_q.push_back(p);
      rr_irq_q.push_back(ic);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      rd("rst_mcycle", 12'hB00, 32'd0, 1'b0);
      rd("rst_mtvec", 12'h305, 32'h0000_0200, 1'b0);
      rd("rst_mcause", 12'h342, 32'd0, 1'b0);
      next();
      @(negedge clk);
      reset = 1'b0;
      repeat (9) @(posedge clk);
      rd("mcycle_10", 12'hB00, 32'd10, 1'b0);
      rd("mhartid", 12'hF14, 32'd5, 1'b0);
      rd("unimpl_7c0", 12'h7C0, 32'd0, 1'b1);
      rd("cycle_shadow", 12'hC00, 32'd13, 1'b0);

      // plain CSR behaviour
      wrd(12'h305, 32'h0000_0103, "mtvec_nobypass", 12'h305, 32'h0000_0200, 1'b0);
      rd("mtvec_align", 12'h305, 32'h0000_0100, 1'b0);
      wrd(12'h340, 32'hDEAD_BEEF, "mscratch_old", 12'h340, 32'd0, 1'b0);
      rd("mscratch", 12'h340, 32'hDEAD_BEEF, 1'b0);
      wrd(12'hC00, 32'h55, "ro_write_illegal", 12'h301, 32'h4000_0100, 1'b1);
      wrd(12'h301, 32'd0, "misa_const", 12'h301, 32'h4000_0100, 1'b0);
      rd("misa_after_wr", 12'h301, 32'h4000_0100, 1'b0);
      wr(12'h304, 32'hFFFF_FFFF);
      wr(12'h300, 32'hFFFF_FFFF);
      rd("mie_meie", 12'h304, 32'h0000_0800, 1'b0);
      rd("mstatus_mask", 12'h300, 32'h0000_0088, 1'b0);

      // interrupt take
      next();
      pc  = 32'h40;
      EIP = 1'b1;
      exp_redirect("irq", 32'h100, 1'b0);
      rd("irq_mepc", 12'h341, 32'h40, 1'b0);
      rd("irq_mcause", 12'h342, 32'h8000_000B, 1'b0);
      rd("irq_mstatus", 12'h300, 32'h0000_0080, 1'b0);
      rd("mip_live", 12'h344, 32'h0000_0800, 1'b0);
      next();
      EIP = 1'b0;
      rd("mip_clear", 12'h344, 32'd0, 1'b0);

      // mret with same-cycle mepc write
      next();
      mret        = 1'b1;
      csr_wr      = 1'b1;
      csr_wr_addr = 12'h341;
      csr_wr_data = 32'h2000;
      exp_redirect("irq_mret", 32'h40, 1'b1);
      rd("mret_mstatus", 12'h300, 32'h0000_0088, 1'b0);
      rd("mret_mepc_wr", 12'h341, 32'h2000, 1'b0);

      // trap + enabled interrupt + mepc write together
      next();
      trap        = 1'b1;
      EIP         = 1'b1;
      pc          = 32'h88;
      csr_wr      = 1'b1;
      csr_wr_addr = 12'h341;
      csr_wr_data = 32'h1234;
      exp_redirect("trap", 32'h100, 1'b0);
      next();
      EIP = 1'b0;
      rd("trap_mcause", 12'h342, 32'd3, 1'b0);
      rd("trap_mepc", 12'h341, 32'h88, 1'b0);
      rd("trap_mstatus", 12'h300, 32'h0000_0080, 1'b0);
      next();
      mret = 1'b1;
      exp_redirect("trap_mret", 32'h88, 1'b0);
      rd("trap_mret_mstatus", 12'h300, 32'h0000_0088, 1'b0);

      // 64-bit counter wrap via split writes
      wr(12'hB00, 32'hFFFF_FFFF);
      wr(12'hB80, 32'hFFFF_FFFF);
      rd("mcycleh_set", 12'hB80, 32'hFFFF_FFFF, 1'b0);
      rd("mcycle_wrap_lo", 12'hB00, 32'd0, 1'b0);
      rd("mcycle_wrap_hi", 12'hB80, 32'd0, 1'b0);

      // instret counting and write-wins
      next();
      retire = 1'b1;
      repeat (4) next();
      rd("minstret_5", 12'hB02, 32'd5, 1'b0);
      retire = 1'b0;
      next();
      retire      = 1'b1;
      csr_wr      = 1'b1;
      csr_wr_addr = 12'hB02;
      csr_wr_data = 32'h100;
      rd("minstret_wr", 12'hB02, 32'h100, 1'b0);
      retire = 1'b0;
      rd("instret_shadow", 12'hC02, 32'h100, 1'b0);
      rd("minstreth", 12'hB82, 32'd0, 1'b0);

      // reset asserted while a redirect is in flight
      next();
      trap = 1'b1;
      pc   = 32'h99;
      @(posedge clk);
      #2;
      reset = 1'b1;
      trap  = 1'b0;
      @(negedge clk);
      chk("rst_abort_valid", {31'd0, redirect_valid}, 32'd0);
      chk("rst_abort_pc", redirect_pc, 32'd0);
      rd("rst2_mepc", 12'h341, 32'd0, 1'b0);
      rd("rst2_mtvec", 12'h305, 32'h0000_0200, 1'b0);
      next();
      @(negedge clk);
      reset = 1'b0;
      rd("rst2_mcycle_1", 12'hB00, 32'd1, 1'b0);
      next();

      chk("rd_scoreboard_drained", 32'(rd_exp_q.size()), 32'd0);
      chk("redirect_scoreboard_drained", 32'(rr_pc_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
